mu0_sequencer: RTL and testbench

//  Fetch/execute control FSM for the MU0 12-bit-address datapath. Drives the
//  12-bit address mux select (PC vs IR[11:0]), the ALU X/Y operand selects,
//  the ALU function code, register enables and memory strobes.

---
 rtl/mu0_sequencer.sv | 116 +++++++++++
 tb/tb_mu0_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 fetch/execute control FSM with fixed memory wait states.
module mu0_sequencer #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output logic       Addr_sel,
    output logic       X_sel,
    output logic       Y_sel,
    output logic [1:0] ALU_fs,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       Mem_rEn,
    output logic       Mem_wEn,
    output logic       Halted,
    output logic [1:0] State
);
    localparam logic [1:0] FETCH = 2'b00;
    localparam logic [1:0] EXEC  = 2'b01;
    localparam logic [1:0] HALT  = 2'b10;
    localparam logic [2:0] LAST  = 3'(WAIT_CYCLES);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       mem_op, last;
    logic       pc_en, ir_en, acc_en, rd, wr;

    assign mem_op = F[3:2] == 2'b00;
    // register-only instructions finish in one cycle regardless of the wait count
    assign last   = (cnt_q == LAST) || (state_q == EXEC && !mem_op);

    always_comb begin
        state_d  = state_q;
        cnt_d    = last ? 3'd0 : cnt_q + 3'd1;
        Addr_sel = 1'b0;
        X_sel    = 1'b0;
        Y_sel    = 1'b0;
        ALU_fs   = 2'b00;
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        acc_en   = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        case (state_q)
            FETCH: begin
                X_sel   = 1'b1;
                ALU_fs  = 2'b10;
                rd      = 1'b1;
                ir_en   = last;
                pc_en   = last;
                state_d = last ? EXEC : FETCH;
            end
            EXEC: begin
                state_d = !last ? EXEC : (F == 4'd7) ? HALT : FETCH;
                case (F)
                    4'd0: begin
                        Addr_sel = 1'b1;
                        rd       = 1'b1;
                        acc_en   = last;
                    end
                    4'd1: begin
                        Addr_sel = 1'b1;
                        wr       = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        Addr_sel = 1'b1;
                        rd       = 1'b1;
                        ALU_fs   = F[0] ? 2'b11 : 2'b01;
                        acc_en   = last;
                    end
                    4'd4: begin
                        Y_sel = 1'b1;
                        pc_en = 1'b1;
                    end
                    4'd5: begin
                        Y_sel = 1'b1;
                        pc_en = !N;
                    end
                    4'd6: begin
                        Y_sel = 1'b1;
                        pc_en = !Z;
                    end
                    default: ;
                endcase
            end
            HALT:    cnt_d = 3'd0;
            default: begin
                state_d = FETCH;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FETCH;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // reset gates every enable so an aborted access leaves no partial write
    assign PC_En   = Reset_n & pc_en;
    assign IR_En   = Reset_n & ir_en;
    assign Acc_En  = Reset_n & acc_en;
    assign Mem_rEn = Reset_n & rd;
    assign Mem_wEn = Reset_n & wr;
    assign Halted  = state_q == HALT;
    assign State   = state_q;
endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: directed checks of the MU0 sequencer with 0 and 2 wait cycles.
module tb_mu0_sequencer;
    logic       clk = 1'b0;
    logic       rst0_n = 1'b0, rst2_n = 1'b0;
    logic [3:0] f = 4'd2;
    logic       n = 1'b0, z = 1'b0;
    logic       a0, x0, y0, pc0, ir0, acc0, r0, w0, h0;
    logic [1:0] fs0, st0;
    logic       a2, x2, y2, pc2, ir2, acc2, r2, w2, h2;
    logic [1:0] fs2, st2;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    mu0_sequencer #(.WAIT_CYCLES(0)) u0 (
        .Clk(clk), .Reset_n(rst0_n), .F(f), .N(n), .Z(z),
        .Addr_sel(a0), .X_sel(x0), .Y_sel(y0), .ALU_fs(fs0), .PC_En(pc0),
        .IR_En(ir0), .Acc_En(acc0), .Mem_rEn(r0), .Mem_wEn(w0),
        .Halted(h0), .State(st0));

    mu0_sequencer #(.WAIT_CYCLES(2)) u2 (
        .Clk(clk), .Reset_n(rst2_n), .F(f), .N(n), .Z(z),
        .Addr_sel(a2), .X_sel(x2), .Y_sel(y2), .ALU_fs(fs2), .PC_En(pc2),
        .IR_En(ir2), .Acc_En(acc2), .Mem_rEn(r2), .Mem_wEn(w2),
        .Halted(h2), .State(st2));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // enables packed as {pc, ir, acc, rd, wr}
    function automatic logic [7:0] en0();
        return {3'b000, pc0, ir0, acc0, r0, w0};
    endfunction

    function automatic logic [7:0] en2();
        return {3'b000, pc2, ir2, acc2, r2, w2};
    endfunction

    initial begin
        tick();
        tick();
        chk("rst_state", {6'd0, st0}, 8'd0);
        chk("rst_en", en0(), 8'h00);
        chk("rst_halted", {7'd0, h0}, 8'd0);
        rst0_n = 1'b1;
        #1;
        chk("fetch_state", {6'd0, st0}, 8'd0);
        chk("fetch_en", en0(), 8'b11010);
        chk("fetch_fs", {6'd0, fs0}, 8'b10);
        chk("fetch_sel", {6'd0, a0, x0}, 8'b01);
        tick();
        chk("add_state", {6'd0, st0}, 8'd1);
        chk("add_sel", {5'd0, a0, x0, y0}, 8'b100);
        chk("add_fs", {6'd0, fs0}, 8'b01);
        chk("add_en", en0(), 8'b00110);
        rst0_n = 1'b0;
        #1;
        chk("abort_state", {6'd0, st0}, 8'd0);
        chk("abort_en", en0(), 8'h00);
        tick();
        rst0_n = 1'b1;
        #1;
        chk("restart_en", en0(), 8'b11010);
        tick();
        chk("add_again", en0(), 8'b00110);
        tick();
        chk("add_back_fetch", {6'd0, st0}, 8'd0);
        f = 4'd3;
        tick();
        chk("sub_fs", {6'd0, fs0}, 8'b11);
        chk("sub_en", en0(), 8'b00110);
        tick();
        f = 4'd5;
        n = 1'b1;
        tick();
        chk("jge_n1_state", {6'd0, st0}, 8'd1);
        chk("jge_n1_en", en0(), 8'h00);
        n = 1'b0;
        #1;
        chk("jge_n0_en", en0(), 8'b10000);
        chk("jge_n0_sel", {5'd0, y0, fs0}, 8'b100);
        tick();
        chk("jge_back_fetch", {6'd0, st0}, 8'd0);
        f = 4'd6;
        z = 1'b1;
        tick();
        chk("jne_z1_en", en0(), 8'h00);
        z = 1'b0;
        #1;
        chk("jne_z0_en", en0(), 8'b10000);
        tick();
        f = 4'd4;
        tick();
        chk("jmp_en", en0(), 8'b10000);
        chk("jmp_sel", {5'd0, y0, fs0}, 8'b100);
        tick();
        f = 4'hA;
        tick();
        chk("nop_state", {6'd0, st0}, 8'd1);
        chk("nop_en", en0(), 8'h00);
        tick();
        chk("nop_back_fetch", {6'd0, st0}, 8'd0);
        f = 4'd1;
        tick();
        chk("sta_en", en0(), 8'b00001);
        chk("sta_addr", {7'd0, a0}, 8'd1);
        tick();
        f = 4'd0;
        tick();
        chk("lda_en", en0(), 8'b00110);
        chk("lda_sel", {5'd0, a0, y0, fs0[0]}, 8'b100);
        tick();
        f = 4'd7;
        tick();
        chk("stp_state", {6'd0, st0}, 8'd1);
        chk("stp_en", en0(), 8'h00);
        chk("stp_not_halted", {7'd0, h0}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            f = 4'(i * 5 + 3);
            n = i[0];
            z = i[1];
            #1;
            chk("halt_state", {6'd0, st0}, 8'd2);
            chk("halt_flag", {7'd0, h0}, 8'd1);
            chk("halt_en", en0(), 8'h00);
        end
        rst0_n = 1'b0;
        #1;
        rst0_n = 1'b1;
        #1;
        chk("unhalt_state", {6'd0, st0}, 8'd0);
        chk("unhalt_flag", {7'd0, h0}, 8'd0);

        f = 4'd0;
        tick();
        rst2_n = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("w2_fetch_state", {6'd0, st2}, 8'd0);
            chk("w2_fetch_en", en2(), (c == 2) ? 8'b11010 : 8'b00010);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            chk("w2_lda_state", {6'd0, st2}, 8'd1);
            chk("w2_lda_en", en2(), (c == 2) ? 8'b00110 : 8'b00010);
            tick();
        end
        chk("w2_back_fetch", {6'd0, st2}, 8'd0);
        chk("w2_refetch_en", en2(), 8'b00010);
        f = 4'd1;
        tick();
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("w2_sta_state", {6'd0, st2}, 8'd1);
            chk("w2_sta_en", en2(), 8'b00001);
            tick();
        end
        chk("w2_sta_done", {6'd0, st2}, 8'd0);
        f = 4'd4;
        tick();
        tick();
        tick();
        chk("w2_jmp_en", en2(), 8'b10000);
        tick();
        chk("w2_jmp_one_cycle", {6'd0, st2}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
